// File: rtl/coin_pkg.sv
// Shared types for the coin pulse conditioner: per-channel FSM state and meter width.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    GAP      = 2'd2,
    WAIT_REL = 2'd3
  } coin_state_t;

  localparam int COIN_METER_W = 8;

endpackage

// File: rtl/coin_channel.sv
// One coin channel: 2-flop synchroniser, ena-timed debounce, and pulse/gap/re-arm FSM.
// COIN_METER_EN adds a per-channel 8-bit press counter on the coin_count port.
module coin_channel
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 1024,
  parameter int PULSE_FRAMES   = 3,
  parameter int GAP_FRAMES     = 3
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic        ena,
  input  logic        frame_tick,
  input  logic        coin_raw,
  output logic        coin_out,
  output coin_state_t state
`ifdef COIN_METER_EN
  ,
  output logic [COIN_METER_W-1:0] coin_count
`endif
);

  localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int FMAX = (PULSE_FRAMES > GAP_FRAMES) ? PULSE_FRAMES : GAP_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic [DW-1:0] deb_cnt;
  logic          deb_accept;
  logic          deb_rise;

  coin_state_t   state_n;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_n;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= coin_raw;
      sync2 <= sync1;
    end
  end

  // The counter only runs while the synchronised level differs from the
  // accepted one, so any bounce back to the old level restarts it.
  assign deb_accept = ena && (sync2 != deb) && (deb_cnt == DW'(DEBOUNCE_TICKS - 1));
  assign deb_rise   = deb_accept && sync2;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (sync2 == deb) begin
      deb_cnt <= '0;
    end else if (ena) begin
      if (deb_accept) begin
        deb     <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    case (state)
      IDLE: begin
        if (deb_rise) begin
          state_n = PULSE;
          fcnt_n  = '0;
        end
      end
      PULSE: begin
        if (frame_tick) begin
          if (fcnt == FW'(PULSE_FRAMES - 1)) begin
            state_n = GAP;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (frame_tick) begin
          if (fcnt == FW'(GAP_FRAMES - 1)) begin
            state_n = WAIT_REL;
            fcnt_n  = '0;
          end else begin
            fcnt_n = fcnt + 1'b1;
          end
        end
      end
      WAIT_REL: begin
        if (!deb) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        fcnt_n  = '0;
      end
    endcase
  end

  // coin_out is registered from the next state so it rises with the PULSE entry edge.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      fcnt     <= '0;
      coin_out <= 1'b0;
    end else begin
      state    <= state_n;
      fcnt     <= fcnt_n;
      coin_out <= (state_n == PULSE);
    end
  end

`ifdef COIN_METER_EN
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      coin_count <= '0;
    end else if (state == IDLE && state_n == PULSE) begin
      coin_count <= coin_count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Coin pulse conditioner top: shared vblank frame tick, NUM_CH coin_channel instances, busy flag.
// COIN_METER_EN exposes per-channel press counters on coin_count.
module coin_pulse_conditioner
  import coin_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int DEBOUNCE_TICKS = 1024,
  parameter int PULSE_FRAMES   = 3,
  parameter int GAP_FRAMES     = 3
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              ena,
  input  logic              vblank,
  input  logic [NUM_CH-1:0] coin_in,
  output logic [NUM_CH-1:0] coin_out,
  output logic              busy
`ifdef COIN_METER_EN
  ,
  output logic [NUM_CH*COIN_METER_W-1:0] coin_count
`endif
);

  logic              vblank_q;
  logic              frame_tick;
  logic [NUM_CH-1:0] active;
  coin_state_t       ch_state [NUM_CH];

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) vblank_q <= 1'b0;
    else          vblank_q <= vblank;
  end

  assign frame_tick = vblank & ~vblank_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    coin_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .PULSE_FRAMES  (PULSE_FRAMES),
      .GAP_FRAMES    (GAP_FRAMES)
    ) u_ch (
      .clk       (clk),
      .RESET_N   (RESET_N),
      .ena       (ena),
      .frame_tick(frame_tick),
      .coin_raw  (coin_in[i]),
      .coin_out  (coin_out[i]),
      .state     (ch_state[i])
`ifdef COIN_METER_EN
      ,
      .coin_count(coin_count[i*COIN_METER_W +: COIN_METER_W])
`endif
    );
    assign active[i] = (ch_state[i] != IDLE);
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) busy <= 1'b0;
    else          busy <= |active;
  end

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Bench for coin_pulse_conditioner: pulse-width scoreboard plus scenario tasks.
// Build with COIN_METER_EN defined to include the coin meter scenario.
module tb_coin_pulse_conditioner;

  localparam int NUM_CH = 2;
  localparam int DT     = 32;
  localparam int PF     = 3;
  localparam int GF     = 3;

  logic              clk = 1'b0;
  logic              RESET_N;
  logic              ena = 1'b0;
  logic              vblank = 1'b0;
  logic [NUM_CH-1:0] coin_in;
  logic [NUM_CH-1:0] coin_out;
  logic              busy;
`ifdef COIN_METER_EN
  logic [NUM_CH*8-1:0] coin_count;
`endif

  coin_pulse_conditioner #(
    .NUM_CH        (NUM_CH),
    .DEBOUNCE_TICKS(DT),
    .PULSE_FRAMES  (PF),
    .GAP_FRAMES    (GF)
  ) dut (
    .clk    (clk),
    .RESET_N(RESET_N),
    .ena    (ena),
    .vblank (vblank),
    .coin_in(coin_in),
    .coin_out(coin_out),
    .busy   (busy)
`ifdef COIN_METER_EN
    ,
    .coin_count(coin_count)
`endif
  );

  // ---------------- clock / timebase ----------------
  always #5 clk = ~clk;

  int ena_div      = 4;
  int ena_cnt      = 0;
  int frame_period = 200;
  int vb_high      = 10;
  int frame_cnt    = 0;

  always @(negedge clk) begin
    ena_cnt = ena_cnt + 1;
    if (ena_cnt >= ena_div) ena_cnt = 0;
    ena = (ena_cnt == 0);
    frame_cnt = frame_cnt + 1;
    if (frame_cnt >= frame_period) frame_cnt = 0;
    vblank = (frame_cnt < vb_high);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  logic [NUM_CH-1:0] prev_out = '0;
  logic vb_last = 1'b0;
  logic tick;
  int   cyc = 0;
  int   tick_cnt [NUM_CH];
  int   rise_cyc [NUM_CH];
  int   pulses   [NUM_CH];
  int   qsize;
  logic [7:0] exp_v;

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      tick_cnt[i] = 0;
      rise_cyc[i] = 0;
      pulses[i]   = 0;
    end
  end

  // Counts the frame ticks the DUT acts on while each coin_out is high; the
  // falling edge must land on a tick and the count must equal the pushed value.
  always @(posedge clk) begin
    #1;
    cyc  = cyc + 1;
    tick = vblank & ~vb_last;
    vb_last = vblank;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (!RESET_N) begin
        prev_out[ch] = 1'b0;
        tick_cnt[ch] = 0;
      end else begin
        if (prev_out[ch] && tick) tick_cnt[ch] = tick_cnt[ch] + 1;
        if (!prev_out[ch] && coin_out[ch]) begin
          rise_cyc[ch] = cyc;
          tick_cnt[ch] = 0;
          pulses[ch]   = pulses[ch] + 1;
          qsize = (ch == 0) ? exp_q0.size() : exp_q1.size();
          checks = checks + 1;
          if (qsize == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_pulse ch%0d at cycle %0d: got rise, expected none", ch, cyc);
          end
        end
        if (prev_out[ch] && !coin_out[ch]) begin
          checks = checks + 1;
          if (!tick) begin
            errors = errors + 1;
            $display("FAIL fall_off_tick ch%0d at cycle %0d: got fall without frame tick", ch, cyc);
          end
          qsize = (ch == 0) ? exp_q0.size() : exp_q1.size();
          if (qsize > 0) begin
            exp_v = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            checks = checks + 1;
            if (tick_cnt[ch] !== int'(exp_v)) begin
              errors = errors + 1;
              $display("FAIL pulse_frames ch%0d: got %0d ticks, expected %0d", ch, tick_cnt[ch], exp_v);
            end
          end
        end
        prev_out[ch] = coin_out[ch];
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    repeat (n) @(posedge vblank);
    @(negedge clk);
  endtask

  task automatic wait_rise(input int ch, input int max);
    int k;
    k = 0;
    while (!coin_out[ch] && k < max) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!coin_out[ch]) begin
      errors++;
      $display("FAIL rise_timeout ch%0d: coin_out stayed 0 for %0d clk, expected pulse", ch, max);
    end
  endtask

  task automatic wait_fall(input int ch, input int max);
    int k;
    k = 0;
    while (coin_out[ch] && k < max) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (coin_out[ch]) begin
      errors++;
      $display("FAIL fall_timeout ch%0d: coin_out stayed 1 for %0d clk, expected end", ch, max);
    end
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    while ((busy || coin_out != '0) && k < max) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy || coin_out != '0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b coin_out=%b after %0d clk, expected 0/00", busy, coin_out, max);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    RESET_N = 1'b0;
    coin_in = '0;
    wait_clks(3);
    checks++;
    if (coin_out !== 2'b00) begin
      errors++;
      $display("FAIL reset_coin_out: got %b, expected 00", coin_out);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, expected 0", busy);
    end
    RESET_N = 1'b1;
    wait_clks(20);
    checks++;
    if (coin_out !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got coin_out=%b busy=%b, expected 00/0", coin_out, busy);
    end
  endtask

  task automatic test_single_press;
    int p0, p1;
    p0 = pulses[0];
    p1 = pulses[1];
    exp_q0.push_back(8'(PF));
    coin_in[0] = 1'b1;
    wait_rise(0, 400);
    wait_frames(1);
    checks++;
    if (coin_out !== 2'b01) begin
      errors++;
      $display("FAIL single_mid_pulse: got %b, expected 01", coin_out);
    end
    wait_frames(19);
    checks++;
    if (coin_out[0] !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_held: got coin_out0=%b busy=%b, expected 0/1", coin_out[0], busy);
    end
    coin_in[0] = 1'b0;
    wait_idle(600);
    checks++;
    if (pulses[0] !== p0 + 1 || pulses[1] !== p1) begin
      errors++;
      $display("FAIL single_count: got ch0=%0d ch1=%0d, expected %0d %0d", pulses[0] - p0, pulses[1] - p1, 1, 0);
    end
  endtask

  task automatic test_rearm;
    int p0;
    p0 = pulses[0];
    wait_frames(2);
    exp_q0.push_back(8'(PF));
    coin_in[0] = 1'b1;
    wait_rise(0, 400);
    // Early release must not shorten the pulse.
    coin_in[0] = 1'b0;
    wait_fall(0, 1000);
    // Press again inside the GAP: must not produce a pulse while held.
    wait_clks(10);
    coin_in[0] = 1'b1;
    wait_frames(GF + 3);
    checks++;
    if (coin_out[0] !== 1'b0 || busy !== 1'b1 || pulses[0] !== p0 + 1) begin
      errors++;
      $display("FAIL gap_press: got coin_out0=%b busy=%b pulses=%0d, expected 0/1/%0d", coin_out[0], busy, pulses[0] - p0, 1);
    end
    coin_in[0] = 1'b0;
    wait_idle(600);
    exp_q0.push_back(8'(PF));
    coin_in[0] = 1'b1;
    wait_rise(0, 400);
    coin_in[0] = 1'b0;
    wait_idle(2000);
    checks++;
    if (pulses[0] !== p0 + 2) begin
      errors++;
      $display("FAIL rearm_count: got %0d pulses, expected 2", pulses[0] - p0);
    end
  endtask

  task automatic test_bounce;
    int p0;
    p0 = pulses[0];
    coin_in[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      coin_in[0] = ~coin_in[0];
      wait_clks(5 * 4);
    end
    coin_in[0] = 1'b0;
    wait_clks(DT * 4 + 50);
    checks++;
    if (pulses[0] !== p0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce: got pulses=%0d busy=%b, expected 0/0", pulses[0] - p0, busy);
    end
    coin_in[0] = 1'b1;
    wait_clks((DT / 2) * 4);
    coin_in[0] = 1'b0;
    wait_clks(DT * 4 + 50);
    checks++;
    if (pulses[0] !== p0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch: got pulses=%0d busy=%b, expected 0/0", pulses[0] - p0, busy);
    end
  endtask

  task automatic test_simultaneous;
    exp_q0.push_back(8'(PF));
    exp_q1.push_back(8'(PF));
    coin_in = 2'b11;
    wait_rise(0, 400);
    wait_clks(2);
    checks++;
    if (coin_out !== 2'b11 || rise_cyc[0] !== rise_cyc[1]) begin
      errors++;
      $display("FAIL sim_start: got coin_out=%b rise0=%0d rise1=%0d, expected 11 equal", coin_out, rise_cyc[0], rise_cyc[1]);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL sim_busy_pulse: got %b, expected 1", busy);
    end
    coin_in = 2'b00;
    wait_fall(0, 1000);
    checks++;
    if (coin_out !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sim_gap: got coin_out=%b busy=%b, expected 00/1", coin_out, busy);
    end
    wait_idle(1000);
  endtask

  task automatic test_reset_mid_pulse;
    int t0, lat;
    exp_q0.push_back(8'(PF));
    coin_in[0] = 1'b1;
    wait_rise(0, 400);
    wait_frames(1);
    exp_q0.delete();
    RESET_N = 1'b0;
    #1;
    checks++;
    if (coin_out !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pulse: got coin_out=%b busy=%b, expected 00/0", coin_out, busy);
    end
    wait_clks(3);
    exp_q0.push_back(8'(PF));
    RESET_N = 1'b1;
    t0 = cyc;
    wait_rise(0, 400);
    lat = rise_cyc[0] - t0;
    checks++;
    if (lat < DT * 4 - 6 || lat > DT * 4 + 8) begin
      errors++;
      $display("FAIL held_through_reset: got latency %0d clk, expected %0d..%0d", lat, DT * 4 - 6, DT * 4 + 8);
    end
    coin_in[0] = 1'b0;
    wait_idle(2000);
  endtask

`ifdef COIN_METER_EN
  task automatic test_meter;
    RESET_N = 1'b0;
    wait_clks(2);
    RESET_N = 1'b1;
    ena_div      = 1;
    frame_period = 16;
    vb_high      = 2;
    wait_clks(20);
    for (int i = 0; i < 257; i++) begin
      exp_q0.push_back(8'(PF));
      coin_in[0] = 1'b1;
      wait_rise(0, 200);
      coin_in[0] = 1'b0;
      wait_idle(400);
    end
    checks++;
    if (coin_count[7:0] !== 8'd1 || coin_count[15:8] !== 8'd0) begin
      errors++;
      $display("FAIL meter: got ch0=%0d ch1=%0d, expected 1 0", coin_count[7:0], coin_count[15:8]);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0;
    coin_in = '0;
    test_reset;
    test_single_press;
    test_rearm;
    test_bounce;
    test_simultaneous;
    test_reset_mid_pulse;
`ifdef COIN_METER_EN
    test_meter;
`endif
    wait_clks(5);
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d/%0d pending, expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
